// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit.
// Holds the MIPS opcode/funct encodings, the sequencer state enum, the
// decoded instruction class, and field-slice helpers used by the top.
package alu_issue_unit_pkg;

   localparam int unsigned REG_W    = 32;
   localparam int unsigned RF_AW    = 5;
   localparam int unsigned RF_DEPTH = 32;

   // opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

   // What the unit does with an instruction after EXEC.
   typedef enum logic [3:0] {
      K_ALU_RD,   // ALU result -> rd
      K_ALU_RT,   // ALU result -> rt
      K_SLTU,     // local unsigned compare -> rd
      K_SLTI,     // local signed compare vs imm -> rt
      K_SLTIU,    // local unsigned compare vs sext(imm) -> rt
      K_BR,       // beq/bne
      K_LW,
      K_SW,
      K_ILL
   } kind_t;

   function automatic logic [RF_AW-1:0] f_rs(input logic [REG_W-1:0] ins);
      return ins[25:21];
   endfunction

   function automatic logic [RF_AW-1:0] f_rt(input logic [REG_W-1:0] ins);
      return ins[20:16];
   endfunction

   function automatic logic [RF_AW-1:0] f_rd(input logic [REG_W-1:0] ins);
      return ins[15:11];
   endfunction

   function automatic logic [REG_W-1:0] f_sext_imm(input logic [REG_W-1:0] ins);
      return {{16{ins[15]}}, ins[15:0]};
   endfunction

   function automatic kind_t f_decode(input logic [REG_W-1:0] ins);
      kind_t k;
      k = K_ILL;
      case (ins[31:26])
         OP_RTYPE: begin
            case (ins[5:0])
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
               FN_SLT, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: k = K_ALU_RD;
               FN_SLTU: k = K_SLTU;
               default: k = K_ILL;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: k = K_ALU_RT;
         OP_SLTI:        k = K_SLTI;
         OP_SLTIU:       k = K_SLTIU;
         OP_BEQ, OP_BNE: k = K_BR;
         OP_LW:          k = K_LW;
         OP_SW:          k = K_SW;
         default:        k = K_ILL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Bus bundle of the ALU issue unit: fetch handshake, ALU operand/result path,
// data-memory request/response, writeback and status pulses.
//   master : the issue unit's view (drives instr_ready, alu_*, mem_req, wb_*, pulses)
//   slave  : the environment's view (fetch, ALU, data memory)
interface alu_issue_unit_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] alu_instruction;
   logic [31:0] alu_regA;
   logic [31:0] alu_regB;
   logic [31:0] alu_result;
   logic        alu_zeroflag;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        mem_req_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        illegal;
   logic        mem_err;

   modport master (
      input  instr_valid, instr, pc, alu_result, alu_zeroflag,
             mem_ready, mem_rvalid, mem_rdata,
      output instr_ready, alu_instruction, alu_regA, alu_regB,
             branch_taken, branch_target, mem_req_valid, mem_we, mem_addr,
             mem_wdata, wb_valid, wb_addr, wb_data, illegal, mem_err
   );

   modport slave (
      output instr_valid, instr, pc, alu_result, alu_zeroflag,
             mem_ready, mem_rvalid, mem_rdata,
      input  instr_ready, alu_instruction, alu_regA, alu_regB,
             branch_taken, branch_target, mem_req_valid, mem_we, mem_addr,
             mem_wdata, wb_valid, wb_addr, wb_data, illegal, mem_err
   );
endinterface

// File: rtl/alu_issue_unit_regfile.sv
// 32x32 MIPS register file.
// Ports: i_clk/i_reset (sync, active-high clears every entry), two
// combinational operand reads (a/b), one combinational debug read, one
// synchronous write port. $0 always reads zero and ignores writes.
module alu_issue_unit_regfile
   import alu_issue_unit_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic [RF_AW-1:0] i_waddr,
   input  logic [REG_W-1:0] i_wdata,
   input  logic [RF_AW-1:0] i_raddr_a,
   input  logic [RF_AW-1:0] i_raddr_b,
   input  logic [RF_AW-1:0] i_dbg_addr,
   output logic [REG_W-1:0] o_rdata_a,
   output logic [REG_W-1:0] o_rdata_b,
   output logic [REG_W-1:0] o_dbg_data
);

   logic [REG_W-1:0] r_rf [RF_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         r_rf[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_rf[i_raddr_a];
   assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_rf[i_raddr_b];
   assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_rf[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: single-issue, non-pipelined sequencer around an external
// combinational MIPS ALU.
// Ports: clk, reset (sync, active-high); bus (alu_issue_unit_if.master) with
// fetch handshake, ALU operands/result, data-memory request/response,
// writeback and illegal/mem_err/branch pulses; i_dbg_addr/o_dbg_data give a
// combinational register-file peek.
// Flow: IDLE (accept, read RF) -> EXEC (sample ALU) -> WB | MEM | IDLE.
module alu_issue_unit
   import alu_issue_unit_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255   // 1..255
) (
   input  logic                clk,
   input  logic                reset,
   alu_issue_unit_if.master    bus,
   input  logic [RF_AW-1:0]    i_dbg_addr,
   output logic [REG_W-1:0]    o_dbg_data
);

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [REG_W-1:0] r_instr, r_pc, r_regA, r_regB;
   logic             r_branch_taken;
   logic [REG_W-1:0] r_branch_target;
   logic             r_mem_req_valid, r_mem_we;
   logic [REG_W-1:0] r_mem_addr, r_mem_wdata;
   logic             r_wb_valid;
   logic [RF_AW-1:0] r_wb_addr;
   logic [REG_W-1:0] r_wb_data;
   logic             r_illegal, r_mem_err;
   logic [7:0]       r_cnt;

   logic [REG_W-1:0] w_rs_data, w_rt_data;
   kind_t            w_kind;
   logic [REG_W-1:0] w_imm;
   logic             w_cmp;
   logic [RF_AW-1:0] w_wb_dest;
   logic [REG_W-1:0] w_wb_res;
   logic [REG_W-1:0] w_br_target;
   logic             w_mem_acc, w_mem_done;

   alu_issue_unit_regfile u_rf (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_we       (r_state == S_WB),
      .i_waddr    (r_wb_addr),
      .i_wdata    (r_wb_data),
      .i_raddr_a  (f_rs(bus.instr)),
      .i_raddr_b  (f_rt(bus.instr)),
      .i_dbg_addr (i_dbg_addr),
      .o_rdata_a  (w_rs_data),
      .o_rdata_b  (w_rt_data),
      .o_dbg_data (o_dbg_data)
   );

   assign w_kind      = f_decode(r_instr);
   assign w_imm       = f_sext_imm(r_instr);
   assign w_br_target = r_pc + 32'd4 + {w_imm[29:0], 2'b00};

   // The external ALU does not return a clean 0/1 for these compares, so
   // they are resolved here from the latched operands.
   always_comb begin
      w_cmp = 1'b0;
      case (w_kind)
         K_SLTU:  w_cmp = (r_regA < r_regB);
         K_SLTI:  w_cmp = ($signed(r_regA) < $signed(w_imm));
         K_SLTIU: w_cmp = (r_regA < w_imm);
         default: w_cmp = 1'b0;
      endcase
   end

   always_comb begin
      w_wb_dest = f_rt(r_instr);
      w_wb_res  = bus.alu_result;
      if (w_kind == K_ALU_RD || w_kind == K_SLTU) w_wb_dest = f_rd(r_instr);
      if (w_kind == K_SLTU || w_kind == K_SLTI || w_kind == K_SLTIU)
         w_wb_res = {31'b0, w_cmp};
   end

   // Request accepted this cycle. A lw completes once read data shows up,
   // either with the accept or in any later cycle.
   assign w_mem_acc  = r_mem_req_valid & bus.mem_ready;
   assign w_mem_done = r_mem_we ? w_mem_acc
                                : ((w_mem_acc | ~r_mem_req_valid) & bus.mem_rvalid);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_instr         <= '0;
         r_pc            <= '0;
         r_regA          <= '0;
         r_regB          <= '0;
         r_branch_taken  <= 1'b0;
         r_branch_target <= '0;
         r_mem_req_valid <= 1'b0;
         r_mem_we        <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wdata     <= '0;
         r_wb_valid      <= 1'b0;
         r_wb_addr       <= '0;
         r_wb_data       <= '0;
         r_illegal       <= 1'b0;
         r_mem_err       <= 1'b0;
         r_cnt           <= '0;
      end else begin
         // single-cycle pulses
         r_branch_taken <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_illegal      <= 1'b0;
         r_mem_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  r_instr <= bus.instr;
                  r_pc    <= bus.pc;
                  r_regA  <= w_rs_data;
                  r_regB  <= w_rt_data;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (w_kind)
                  K_ALU_RD, K_ALU_RT, K_SLTU, K_SLTI, K_SLTIU: begin
                     r_wb_valid <= 1'b1;
                     r_wb_addr  <= w_wb_dest;
                     r_wb_data  <= w_wb_res;
                     r_state    <= S_WB;
                  end
                  K_BR: begin
                     r_branch_taken  <= bus.alu_zeroflag;
                     r_branch_target <= w_br_target;
                     r_state         <= S_IDLE;
                  end
                  K_LW, K_SW: begin
                     r_mem_req_valid <= 1'b1;
                     r_mem_we        <= (w_kind == K_SW);
                     r_mem_addr      <= bus.alu_result;
                     r_mem_wdata     <= r_regB;
                     r_cnt           <= '0;
                     r_state         <= S_MEM;
                  end
                  default: begin
                     r_illegal <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               endcase
            end
            S_MEM: begin
               if (w_mem_done) begin
                  r_mem_req_valid <= 1'b0;
                  if (r_mem_we) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_wb_valid <= 1'b1;
                     r_wb_addr  <= f_rt(r_instr);
                     r_wb_data  <= bus.mem_rdata;
                     r_state    <= S_WB;
                  end
               end else if (w_mem_acc) begin
                  // lw accepted, read data still outstanding: restart the wait
                  r_mem_req_valid <= 1'b0;
                  r_cnt           <= '0;
               end else if (r_cnt == TO_LAST) begin
                  r_mem_req_valid <= 1'b0;
                  r_mem_err       <= 1'b1;
                  r_state         <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_WB:    r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready     = (r_state == S_IDLE);
   assign bus.alu_instruction = r_instr;
   assign bus.alu_regA        = r_regA;
   assign bus.alu_regB        = r_regB;
   assign bus.branch_taken    = r_branch_taken;
   assign bus.branch_target   = r_branch_target;
   assign bus.mem_req_valid   = r_mem_req_valid;
   assign bus.mem_we          = r_mem_we;
   assign bus.mem_addr        = r_mem_addr;
   assign bus.mem_wdata       = r_mem_wdata;
   assign bus.wb_valid        = r_wb_valid;
   assign bus.wb_addr         = r_wb_addr;
   assign bus.wb_data         = r_wb_data;
   assign bus.illegal         = r_illegal;
   assign bus.mem_err         = r_mem_err;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed MIPS instructions, a small behavioural
// ALU and a hand-driven data memory. Each issued instruction pushes its
// expected outcome; a monitor collects pulses and compares when the unit
// returns to ready.
module tb_alu_issue_unit;

   typedef struct packed {
      logic        wb;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        br;
      logic [31:0] bt;
      logic        ill;
      logic        err;
   } outc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] a_imm;

   int    total = 0;
   int    bad   = 0;
   int    seq   = 0;
   bit    mon_en = 1'b0;
   bit    prev_rdy = 1'b1;
   outc_t acc = '0;
   outc_t exp_q[$];

   alu_issue_unit_if bus();

   alu_issue_unit #(.MEM_TIMEOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .i_dbg_addr (dbg_addr),
      .o_dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural ALU covering the ops used here; slt-family ops return junk
   // on purpose so the unit must use its own compare.
   always_comb begin
      a_imm = {{16{bus.alu_instruction[15]}}, bus.alu_instruction[15:0]};
      bus.alu_result   = 32'hFFFF_FFFF;
      bus.alu_zeroflag = 1'b0;
      case (bus.alu_instruction[31:26])
         6'h00: if (bus.alu_instruction[5:0] == 6'h20)
                   bus.alu_result = bus.alu_regA + bus.alu_regB;
         6'h08, 6'h23, 6'h2B: bus.alu_result = bus.alu_regA + a_imm;
         6'h04: bus.alu_zeroflag = (bus.alu_regA == bus.alu_regB);
         6'h05: bus.alu_zeroflag = (bus.alu_regA != bus.alu_regB);
         default: ;
      endcase
   end

   function automatic outc_t o_wb(input logic [4:0] a, input logic [31:0] d);
      outc_t o = '0;
      o.wb = 1'b1; o.wa = a; o.wd = d;
      return o;
   endfunction

   function automatic outc_t o_br(input logic [31:0] t);
      outc_t o = '0;
      o.br = 1'b1; o.bt = t;
      return o;
   endfunction

   function automatic outc_t o_flag(input logic ill, input logic err);
      outc_t o = '0;
      o.ill = ill; o.err = err;
      return o;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.wb_valid) begin acc.wb = 1'b1; acc.wa = bus.wb_addr; acc.wd = bus.wb_data; end
         if (bus.branch_taken) begin acc.br = 1'b1; acc.bt = bus.branch_target; end
         if (bus.illegal) acc.ill = 1'b1;
         if (bus.mem_err) acc.err = 1'b1;
         if (bus.instr_ready && !prev_rdy) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL outcome#%0d unexpected completion: got wb=%b %0d/%h br=%b %h ill=%b err=%b",
                        seq, acc.wb, acc.wa, acc.wd, acc.br, acc.bt, acc.ill, acc.err);
            end else begin
               outc_t e;
               e = exp_q.pop_front();
               if (acc !== e) begin
                  bad++;
                  $display("FAIL outcome#%0d got wb=%b %0d/%h br=%b %h ill=%b err=%b want wb=%b %0d/%h br=%b %h ill=%b err=%b",
                           seq, acc.wb, acc.wa, acc.wd, acc.br, acc.bt, acc.ill, acc.err,
                           e.wb, e.wa, e.wd, e.br, e.bt, e.ill, e.err);
               end
            end
            seq++;
            acc = '0;
         end
         prev_rdy = bus.instr_ready;
      end
   end

   task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.instr_ready && n < 600) begin @(negedge clk); n++; end
      if (!bus.instr_ready) begin
         total++; bad++;
         $display("FAIL wait_ready: timed out after %0d cycles", n);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      @(negedge clk);
      while (!bus.mem_req_valid && n < 50) begin @(negedge clk); n++; end
      if (!bus.mem_req_valid) begin
         total++; bad++;
         $display("FAIL wait_req: no mem_req_valid after %0d cycles", n);
      end
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] p, input outc_t e);
      exp_q.push_back(e);
      wait_ready();
      bus.instr = ins;
      bus.pc = p;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
   endtask

   task automatic dbg_chk(input string nm, input logic [4:0] a, input logic [31:0] want);
      dbg_addr = a;
      #1;
      chk(nm, 96'(dbg_data), 96'(want));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] orv;
      int c;
      reset = 1'b1;
      dbg_addr = '0;
      bus.instr_valid = 1'b0; bus.instr = '0; bus.pc = '0;
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      @(posedge clk); #1;
      chk("rst_ready", 96'(bus.instr_ready), 96'(1'b1));
      @(posedge clk); #1 reset = 1'b0;
      chk("rst_pulses", 96'({bus.wb_valid, bus.branch_taken, bus.mem_req_valid, bus.illegal, bus.mem_err}), 96'(5'b0));
      chk("rst_regs", 96'({bus.alu_instruction, bus.alu_regA, bus.mem_addr}), 96'(0));
      mon_en = 1'b1;

      // addi $1,$0,5 with cycle-accurate latency check
      issue(32'h2001_0005, 32'h0, o_wb(5'd1, 32'd5));
      @(negedge clk) chk("lat_n1 {ready,wb}", 96'({bus.instr_ready, bus.wb_valid}), 96'(2'b00));
      @(negedge clk) chk("lat_n2 {ready,wb}", 96'({bus.instr_ready, bus.wb_valid}), 96'(2'b01));
      @(negedge clk) chk("lat_n3 {ready,wb}", 96'({bus.instr_ready, bus.wb_valid}), 96'(2'b10));
      dbg_chk("dbg r1", 5'd1, 32'd5);

      // addi $2,$0,7 ; add $3,$1,$2 ; addi $0,$0,9
      issue(32'h2002_0007, 32'h0, o_wb(5'd2, 32'd7));
      issue(32'h0022_1820, 32'h0, o_wb(5'd3, 32'd12));
      issue(32'h2000_0009, 32'h0, o_wb(5'd0, 32'd9));
      wait_ready();
      dbg_chk("dbg r0", 5'd0, 32'd0);
      dbg_chk("dbg r3", 5'd3, 32'd12);

      // beq $1,$1,+4 at 0x100 -> 0x114 ; bne $1,$1 -> not taken
      issue(32'h1021_0004, 32'h100, o_br(32'h114));
      issue(32'h1421_0004, 32'h100, '0);

      // sltiu $5,$1,-1 ; slti $5,$1,-1 ; sltu $6,$1,$2 ; funct 0x3F
      issue(32'h2C25_FFFF, 32'h0, o_wb(5'd5, 32'd1));
      issue(32'h2825_FFFF, 32'h0, o_wb(5'd5, 32'd0));
      issue(32'h0022_302B, 32'h0, o_wb(5'd6, 32'd1));
      issue(32'h0000_003F, 32'h0, o_flag(1'b1, 1'b0));

      // sw $1,8($0), memory stalls three cycles
      issue(32'hAC01_0008, 32'h0, '0);
      wait_req();
      chk("sw_req c1", 96'({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}), {62'b0, 1'b1, 1'b1, 32'd8, 32'd5});
      @(negedge clk);
      chk("sw_req c2", 96'({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}), {62'b0, 1'b1, 1'b1, 32'd8, 32'd5});
      @(negedge clk);
      chk("sw_req c3", 96'({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}), {62'b0, 1'b1, 1'b1, 32'd8, 32'd5});
      bus.mem_ready = 1'b1;
      @(posedge clk); #1 bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("sw_done {req,ready}", 96'({bus.mem_req_valid, bus.instr_ready}), 96'(2'b01));

      // lw $4,8($0), data returned with the accept
      issue(32'h8C04_0008, 32'h0, o_wb(5'd4, 32'hDEAD_BEEF));
      wait_req();
      chk("lw_req {req,we,addr}", 96'({bus.mem_req_valid, bus.mem_we, bus.mem_addr}), 96'({1'b1, 1'b0, 32'd8}));
      bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      wait_ready();
      dbg_chk("dbg r4", 5'd4, 32'hDEAD_BEEF);

      // lw $7,0($0) that never gets mem_ready -> timeout
      issue(32'h8C07_0000, 32'h0, o_flag(1'b0, 1'b1));
      c = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.mem_err) break;
         if (bus.mem_req_valid) c++;
      end
      chk("timeout req cycles", 96'(c), 96'(255));
      chk("timeout {err,ready,req}", 96'({bus.mem_err, bus.instr_ready, bus.mem_req_valid}), 96'(3'b110));

      // reset while a lw waits in MEM
      issue(32'h8C08_0000, 32'h0, '0);
      wait_req();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("midrst {req,ready,wb,err}", 96'({bus.mem_req_valid, bus.instr_ready, bus.wb_valid, bus.mem_err}), 96'(4'b0100));
      orv = '0;
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1 orv = orv | dbg_data;
      end
      chk("midrst rf cleared", 96'(orv), 96'(0));

      // unit still works after the reset
      issue(32'h2001_0005, 32'h0, o_wb(5'd1, 32'd5));
      wait_ready();
      repeat (2) @(negedge clk);
      chk("scoreboard drained", 96'(exp_q.size()), 96'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
